// File: rtl/jt7759_seq.sv
// jt7759_seq: uPD7759-style ROM command sequencer with a request queue, loops and stop.
// Byte accepts in fetch states wait for cen4; PLAY buffers one byte and emits nibbles on cendec.
module jt7759_seq #(
   parameter int AW = 17,
   parameter int QW = 2,
   parameter int MW = 13
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen4,
   input  logic          cendec,
   input  logic          wr,
   input  logic [7:0]    din,
   input  logic          stop,
   output logic          busyn,
   output logic          qfull,
   output logic [5:0]    divby,
   output logic          dec_rst,
   output logic [3:0]    dec_din,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok
);
   localparam int QD = 1 << QW;
   typedef enum logic [2:0] {IDLE, ADRH, ADRL, CMD, LEN, MUTE, PLAY} st_t;
   st_t           st_q, st_d;
   logic [7:0]    qm_q [QD];
   logic [7:0]    qm_d [QD];
   logic [QW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [QW:0]   cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d, loop_q, loop_d;
   logic          cs_q, cs_d, chg_q, chg_d, drst_q, drst_d, bv_q, bv_d, half_q, half_d;
   logic [7:0]    byte_q, byte_d;
   logic [2:0]    rep_q, rep_d;
   logic [MW-1:0] mute_q, mute_d;
   logic [8:0]    ncnt_q, ncnt_d;
   logic [5:0]    div_q, div_d;
   logic [3:0]    nib_q, nib_d;
   logic          ok, acc, push, pop;
   // rom_data is only trusted once rom_addr has been stable for a full clk
   assign ok       = cs_q & rom_ok & ~chg_q;
   assign acc      = ok & cen4;
   assign qfull    = cnt_q[QW];
   assign push     = wr & ~qfull & ~stop;
   assign pop      = st_q == IDLE && cnt_q != '0 && !stop;
   assign busyn    = st_q == IDLE && cnt_q == '0;
   assign divby    = div_q;
   assign dec_rst  = drst_q;
   assign dec_din  = nib_q;
   assign rom_cs   = cs_q;
   assign rom_addr = addr_q;
   always_comb begin
      st_d   = st_q;
      qm_d   = qm_q;
      wp_d   = wp_q + QW'(push);
      rp_d   = rp_q + QW'(pop);
      cnt_d  = cnt_q + (QW+1)'(push) - (QW+1)'(pop);
      addr_d = addr_q;
      cs_d   = cs_q;
      byte_d = byte_q;
      rep_d  = rep_q;
      loop_d = loop_q;
      mute_d = mute_q;
      ncnt_d = ncnt_q;
      div_d  = div_q;
      drst_d = drst_q;
      nib_d  = nib_q;
      bv_d   = bv_q;
      half_d = half_q;
      if (push) qm_d[wp_q] = din;
      if (stop) begin
         st_d   = IDLE;
         cs_d   = 1'b0;
         drst_d = 1'b1;
         rp_d   = wp_q;
         cnt_d  = '0;
      end else case (st_q)
         IDLE: begin
            drst_d = 1'b1;
            cs_d   = 1'b0;
            if (pop) begin
               addr_d = AW'({qm_q[rp_q], 1'b0}) + AW'(5);
               cs_d   = 1'b1;
               st_d   = ADRH;
            end
         end
         ADRH: if (acc) begin
            byte_d = rom_data;
            addr_d = addr_q + AW'(1);
            st_d   = ADRL;
         end
         ADRL: if (acc) begin
            addr_d = AW'({byte_q, rom_data, 1'b1});
            rep_d  = '0;
            st_d   = CMD;
         end
         CMD: if (acc) begin
            addr_d = addr_q + AW'(1);
            if (rom_data == 8'h00) begin
               if (rep_q != '0) begin
                  rep_d  = rep_q - 3'd1;
                  addr_d = loop_q;
               end else begin
                  cs_d   = 1'b0;
                  drst_d = 1'b1;
                  st_d   = IDLE;
               end
            end else case (rom_data[7:6])
               2'b00: begin
                  mute_d = MW'({rom_data[5:0], 7'b0});
                  cs_d   = 1'b0;
                  drst_d = 1'b1;
                  st_d   = MUTE;
               end
               2'b01: begin
                  div_d  = rom_data[5:0];
                  ncnt_d = 9'd256;
                  bv_d   = 1'b0;
                  half_d = 1'b0;
                  st_d   = PLAY;
               end
               2'b10: begin
                  div_d = rom_data[5:0];
                  st_d  = LEN;
               end
               default: begin
                  rep_d  = rom_data[2:0];
                  loop_d = addr_q + AW'(1);
               end
            endcase
         end
         LEN: if (acc) begin
            ncnt_d = {1'b0, rom_data} + 9'd1;
            addr_d = addr_q + AW'(1);
            bv_d   = 1'b0;
            half_d = 1'b0;
            st_d   = PLAY;
         end
         MUTE: begin
            drst_d = 1'b1;
            if (cen4) begin
               if (mute_q == '0) begin
                  cs_d = 1'b1;
                  st_d = CMD;
               end else mute_d = mute_q - MW'(1);
            end
         end
         PLAY: begin
            if (!bv_q && ok) begin
               byte_d = rom_data;
               bv_d   = 1'b1;
               cs_d   = 1'b0;
            end
            // a nibble is only emitted from a byte buffered before this cendec
            if (cendec && bv_q) begin
               drst_d = 1'b0;
               nib_d  = half_q ? byte_q[3:0] : byte_q[7:4];
               half_d = ~half_q;
               ncnt_d = ncnt_q - 9'd1;
               if (half_q || ncnt_q == 9'd1) begin
                  bv_d   = 1'b0;
                  half_d = 1'b0;
                  addr_d = addr_q + AW'(1);
                  cs_d   = 1'b1;
               end
               if (ncnt_q == 9'd1) st_d = CMD;
            end
         end
         default: st_d = IDLE;
      endcase
      chg_d = addr_d != addr_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= IDLE;
         qm_q   <= '{default: '0};
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
         cs_q   <= 1'b0;
         chg_q  <= 1'b0;
         byte_q <= '0;
         rep_q  <= '0;
         loop_q <= '0;
         mute_q <= '0;
         ncnt_q <= '0;
         div_q  <= 6'd1;
         drst_q <= 1'b1;
         nib_q  <= '0;
         bv_q   <= 1'b0;
         half_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         qm_q   <= qm_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         cs_q   <= cs_d;
         chg_q  <= chg_d;
         byte_q <= byte_d;
         rep_q  <= rep_d;
         loop_q <= loop_d;
         mute_q <= mute_d;
         ncnt_q <= ncnt_d;
         div_q  <= div_d;
         drst_q <= drst_d;
         nib_q  <= nib_d;
         bv_q   <= bv_d;
         half_q <= half_d;
      end
   end
endmodule

// File: tb/tb_jt7759_seq.sv
// tb_jt7759_seq: directed bench; a ROM-walking model predicts every emitted nibble and its divider.
module tb_jt7759_seq;
   localparam int AW = 17;
   localparam int M  = 1 << AW;
   typedef struct packed {logic [5:0] div; logic [3:0] nib;} ent_t;
   logic          rst = 1'b1, clk = 1'b0, cen4 = 1'b0, cendec = 1'b0, wr = 1'b0, stop = 1'b0;
   logic [7:0]    din = '0;
   logic          busyn, qfull, dec_rst, rom_cs, rom_ok;
   logic [5:0]    divby;
   logic [3:0]    dec_din;
   logic [AW-1:0] rom_addr, addr_prev;
   logic [7:0]    rom_data;
   logic [7:0]    mem [M];
   ent_t          exp_q [$];
   logic [AW-1:0] alog [$];
   int            tests = 0, fails = 0, cyc = 0, run = 0, max_run = 0;
   logic          prev_cs = 1'b0, prev_busyn = 1'b1;

   jt7759_seq dut (
      .rst(rst), .clk(clk), .cen4(cen4), .cendec(cendec), .wr(wr), .din(din), .stop(stop),
      .busyn(busyn), .qfull(qfull), .divby(divby), .dec_rst(dec_rst), .dec_din(dec_din),
      .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
   );

   always #5 clk = ~clk;
   // ROM returns garbage during the first clk after an address change
   always @(posedge clk) addr_prev <= rom_addr;
   assign rom_data = (rom_addr == addr_prev) ? mem[rom_addr] : 8'hEE;
   assign rom_ok   = rom_cs;

   initial forever begin
      @(negedge clk);
      cyc++;
      cen4   = (cyc % 4 == 1);
      cendec = (cyc % 32 == 7);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic expect_sample(input int n);
      int a, la, rep, cnt;
      logic [7:0] b, d;
      ent_t e;
      a   = (int'({mem[2*n+5], mem[2*n+6]}) * 2 + 1) % M;
      rep = 0;
      la  = 0;
      for (int g = 0; g < 64; g++) begin
         b = mem[a];
         a = (a + 1) % M;
         if (b == 8'h00) begin
            if (rep > 0) begin
               rep--;
               a = la;
            end else break;
         end else if (b[7:6] == 2'b11) begin
            rep = int'(b[2:0]);
            la  = a;
         end else if (b[7:6] != 2'b00) begin
            cnt = 256;
            if (b[7]) begin
               cnt = int'(mem[a]) + 1;
               a   = (a + 1) % M;
            end
            for (int i = 0; i < cnt; i++) begin
               d     = mem[(a + i / 2) % M];
               e.div = b[5:0];
               e.nib = (i % 2 == 0) ? d[7:4] : d[3:0];
               exp_q.push_back(e);
            end
            a = (a + (cnt + 1) / 2) % M;
         end
      end
   endtask

   task automatic push(input logic [7:0] v);
      din = v;
      wr  = 1'b1;
      @(negedge clk);
      wr  = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      for (int i = 0; i < lim && !busyn; i++) @(negedge clk);
      chk("idle_timeout", busyn, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busyn"}, busyn, 1);
      chk({tag, "_qfull"}, qfull, 0);
      chk({tag, "_divby"}, divby, 1);
      chk({tag, "_dec_rst"}, dec_rst, 1);
      chk({tag, "_dec_din"}, dec_din, 0);
      chk({tag, "_rom_cs"}, rom_cs, 0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
   endtask

   // compare process: every cendec with the decoder running must carry the next predicted nibble
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         run        = 0;
         prev_cs    = 1'b0;
         prev_busyn = 1'b1;
      end else begin
         if (cendec && !dec_rst) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_nibble: got %0h, expected none", dec_din);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("nibble", dec_din, e.nib);
               chk("divby", divby, e.div);
            end
         end
         if (cen4 && !prev_busyn && !prev_cs) run++;
         if (rom_cs && run > 0) begin
            if (run > max_run) max_run = run;
            run = 0;
         end
         if (rom_cs && alog.size() < 8 && (alog.size() == 0 || alog[$] != rom_addr)) alog.push_back(rom_addr);
         prev_cs    = rom_cs;
         prev_busyn = busyn;
      end
   end

   initial begin
      for (int i = 0; i < M; i++) mem[i] = 8'h00;
      {mem[5], mem[6]}   = 16'h0080;
      {mem[7], mem[8]}   = 16'h0300;
      {mem[9], mem[10]}  = 16'h01C0;
      {mem[11], mem[12]} = 16'h0120;
      mem['h101] = 8'h45;
      for (int i = 0; i < 128; i++) mem['h102 + i] = 8'(i * 7 + 3);
      {mem['h241], mem['h242], mem['h243], mem['h244], mem['h245]} = 40'h80_04_A1_B2_C3;
      {mem['h381], mem['h382], mem['h383]} = 24'h03_C2_41;
      for (int i = 0; i < 128; i++) mem['h384 + i] = 8'(255 - 2 * i);
      {mem['h601], mem['h602], mem['h603]} = 24'h82_00_5A;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      // header fetch plus long play with odd count
      expect_sample(3);
      chk("model_s3_len", exp_q.size(), 5);
      chk("model_s3_first", exp_q[0].nib, 4'hA);
      chk("model_s3_last", exp_q[4].nib, 4'hC);
      alog.delete();
      push(8'd3);
      wait_idle(3000);
      chk("hdr_log_size", alog.size() >= 3, 1);
      while (alog.size() < 3) alog.push_back('0);
      chk("hdr_addr0", alog[0], 11);
      chk("hdr_addr1", alog[1], 12);
      chk("hdr_addr2", alog[2], 'h241);
      chk("s3_dec_rst", dec_rst, 1);
      chk("s3_dec_din_hold", dec_din, 4'hC);
      chk("s3_drained", exp_q.size(), 0);
      // short play, 256 nibbles
      expect_sample(0);
      chk("model_s0_len", exp_q.size(), 256);
      chk("model_s0_n1", exp_q[1].nib, 4'h3);
      chk("model_s0_n3", exp_q[3].nib, 4'hA);
      chk("model_s0_div", exp_q[0].div, 5);
      push(8'd0);
      wait_idle(20000);
      chk("s0_drained", exp_q.size(), 0);
      chk("s0_divby", divby, 5);
      // asynchronous reset while muted
      expect_sample(2);
      chk("model_s2_len", exp_q.size(), 768);
      push(8'd2);
      repeat (400) @(negedge clk);
      chk("mute_rom_cs", rom_cs, 0);
      chk("mute_dec_rst", dec_rst, 1);
      chk("mute_busyn", busyn, 0);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("async_rst");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      // mute length and triple repeat
      max_run = 0;
      expect_sample(2);
      push(8'd2);
      wait_idle(40000);
      chk("mute_len", max_run, 385);
      chk("s2_drained", exp_q.size(), 0);
      chk("s2_divby", divby, 1);
      chk("s2_dec_rst", dec_rst, 1);
      // queue full while a long sample plays
      expect_sample(0);
      push(8'd0);
      repeat (50) @(negedge clk);
      push(8'd1);
      chk("q_full_1", qfull, 0);
      push(8'd3);
      chk("q_full_2", qfull, 0);
      push(8'd1);
      chk("q_full_3", qfull, 0);
      push(8'd3);
      chk("q_full_4", qfull, 1);
      push(8'd2);
      chk("q_full_5", qfull, 1);
      chk("q_busyn", busyn, 0);
      expect_sample(1);
      chk("model_s1_last", exp_q[$].nib, 4'h5);
      chk("model_s1_div", exp_q[$].div, 2);
      expect_sample(3);
      expect_sample(1);
      expect_sample(3);
      wait_idle(30000);
      chk("q_drained", exp_q.size(), 0);
      chk("q_qfull_end", qfull, 0);
      // stop during PLAY with two requests queued, wr in the same clk
      expect_sample(0);
      push(8'd0);
      push(8'd1);
      push(8'd1);
      repeat (300) @(negedge clk);
      chk("stop_pre_busyn", busyn, 0);
      chk("stop_pre_dec_rst", dec_rst, 0);
      stop = 1'b1;
      wr   = 1'b1;
      din  = 8'd3;
      @(negedge clk);
      stop = 1'b0;
      wr   = 1'b0;
      chk("stop_busyn", busyn, 1);
      chk("stop_rom_cs", rom_cs, 0);
      chk("stop_dec_rst", dec_rst, 1);
      chk("stop_qfull", qfull, 0);
      exp_q.delete();
      repeat (200) @(negedge clk);
      chk("stop_still_idle", busyn, 1);
      chk("stop_still_cs", rom_cs, 0);
      chk("final_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/jt7759_seq.md
Name: jt7759_seq

Overview:
- Parametrised successor to the uPD7759 ROM command controller.
- Accepts sample numbers from the CPU side into a request queue and plays them back-to-back.
- For each sample it fetches the start pointer from the ROM header table, parses the command stream (silence, short play, long play, repeat), and feeds 4-bit ADPCM nibbles to the decoder.
- Adds configurable ROM width, queued requests, real loop support and an immediate stop.

Parameters:
- AW, 17: ROM byte-address width; must be at least 17.
- QW, 2: log2 of the request-queue depth (depth = 2^QW).
- MW, 13: mute counter width; must be at least 13.

Ports:
- rst  input  1  asynchronous active-high reset
- clk  input  1  system clock
- cen4  input  1  640 kHz control clock enable
- cendec  input  1  decoder nibble clock enable
- wr  input  1  one-clk request strobe; pushes din into the queue
- din  input  8  sample number
- stop  input  1  abort playback and flush the queue
- busyn  output  1  high when IDLE and the queue is empty
- qfull  output  1  request queue full
- divby  output  6  decoder rate divider taken from the play command
- dec_rst  output  1  decoder reset/mute
- dec_din  output  4  ADPCM nibble
- rom_cs  output  1  ROM read request
- rom_addr  output  AW  ROM byte address
- rom_data  input  8  ROM byte
- rom_ok  input  1  rom_data valid for the current rom_addr

Behaviour:
- Reset values:
  - State IDLE, queue empty.
  - busyn=1, qfull=0, divby=1, dec_rst=1, dec_din=0, rom_cs=0, rom_addr=0.
  - Repeat count 0, loop address 0.
- ROM handshake:
  - rom_addr changes only while rom_cs=0 or in the same cycle a byte is accepted.
  - rom_ok is ignored in the first clk after any rom_addr change.
  - A byte is accepted when rom_cs=1 and rom_ok=1, and the wait condition applies.
  - There is no timeout; the FSM waits indefinitely.
- Request queue:
  - wr with !qfull pushes din.
  - wr with qfull drops the request; the queue is unchanged.
  - A push and a pop in the same clk leave the count unchanged.
- State machine (all states except IDLE advance only on cen4, except PLAY):
  - IDLE: dec_rst=1, rom_cs=0. If the queue is non-empty, pop n, set rom_addr=2n+5, assert rom_cs, go to ADRH.
  - ADRH: on accept, latch the high byte and increment rom_addr; go to ADRL.
  - ADRL: on accept, form pointer p={high,low}. Set rom_addr={zero-extended p,1'b1}, clear repeat count, go to CMD.
  - CMD: on accept, increment rom_addr and decode:
    - 0x00: if repeat count is greater than 0, decrement it and set rom_addr to the loop address (stay in CMD). Otherwise go to IDLE.
    - 00dddddd with d>0: load mute count with d·128, drop rom_cs, go to MUTE.
    - 01dddddd: divby=d, nibble count = 256, go to PLAY.
    - 10dddddd: divby=d, go to LEN.
    - 11xxxrrr: repeat count = r, loop address = address after this byte; stay in CMD.
  - LEN: on accept, nibble count = byte+1 (range 1..256), increment rom_addr, go to PLAY.
  - MUTE: dec_rst=1. Each cen4 decrements the counter; on the cen4 where the counter is 0, re-assert rom_cs and go to CMD. Total length is d·128+1 cen4 ticks.
  - PLAY: each cendec emits one nibble into dec_din with dec_rst=0.
    - High nibble first, taken from the accepted byte; the low nibble on the next cendec, after which rom_addr increments.
    - If a byte has not been accepted by its cendec, the nibble is skipped.
    - When the nibble count reaches 0, go to CMD; dec_din holds its value.
    - An odd count consumes the last byte's high nibble only; the next command is read from the following byte.
- stop: in any clk with stop=1:
  - The queue is flushed, rom_cs=0, dec_rst=1.
  - Next state is IDLE, even mid-fetch.
  - A wr in the same clk is discarded.
  - A stop asserted while in IDLE only flushes the queue.
- Address wrap: rom_addr wraps modulo 2^AW.
- Reset mid-operation returns all outputs to their reset values immediately.

Test Plan:
- Queue full: QW=2, five wr pulses while a long sample plays -> qfull=1 after the 4th; the 5th is dropped; the four samples play in order, then busyn=1.
- Header fetch: wr din=3 with table bytes at 11 and 12 = 0x01 and 0x20 -> rom_addr steps 11, 12, then 0x241.
- Short play: command 0x45 -> divby=5, exactly 256 nibbles (128 bytes) high-first, then the next command is fetched.
- Long play and odd count: commands 0x80, 0x04 -> 5 nibbles; the third byte contributes its high nibble only; 0x00 -> IDLE, dec_rst=1.
- Mute and repeat:
  - 0x03 -> MUTE lasts 385 cen4 ticks with dec_rst=1.
  - 0xC2, 0x41, 0x00 -> the 0x41 block plays 3 times in total, then IDLE.
- Stop and reset: stop pulse during PLAY with 2 queued requests -> next clk IDLE, queue empty, rom_cs=0; asynchronous rst in MUTE -> all outputs immediately return to reset values.
